// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the buffered UART transmitter.
//   tx_state_t  : transmitter FSM state encoding (2 bits)
//   LINE_IDLE   : line level while idle / during the stop bit
//   LINE_START  : line level during the start bit
//   DATA_BITS   : payload bits per frame (8N1)
//   baud_div()  : clock cycles per bit, truncating integer division
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam int   DATA_BITS  = 8;

    // Cycles per bit; the remainder is deliberately discarded.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy count. Pushes while full and pops while
// empty are ignored; the caller owns any overflow reporting.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-low reset (pointers and level cleared)
//   push     in   enqueue wr_data (ignored when full)
//   wr_data  in   WIDTH  data to enqueue
//   pop      in   dequeue the head (ignored when empty)
//   rd_data  out  WIDTH  current head entry
//   level    out  $clog2(DEPTH+1)  occupancy
//   full     out  level == DEPTH
//   empty    out  level == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full/empty come from the registered level so status never depends on
    // this cycle's push or pop.
    assign full      = (level_r == LVL_FULL);
    assign empty     = (level_r == {LW{1'b0}});
    assign level     = level_r;
    assign rd_data   = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; data needs no reset because level guards every read.
    always_ff @(posedge clk) begin
        if (reset && push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8N1 UART transmitter. Bytes stored by the CPU are queued in a
// FIFO and serialised LSB first at CLK_FREQ_HZ/BAUD cycles per bit.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-low reset
//   wr_en     in   one-cycle write strobe
//   wr_data   in   8  byte to enqueue
//   full      out  FIFO holds FIFO_DEPTH entries
//   level     out  $clog2(FIFO_DEPTH+1)  FIFO occupancy (excludes byte on line)
//   busy      out  transmitter active or bytes pending
//   overflow  out  sticky: a write arrived while full
//   txd       out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD        = 115_200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [7:0]                        wr_data,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic                              busy,
    output logic                              overflow,
    output logic                              txd
);

    localparam int DIV   = baud_div(CLK_FREQ_HZ, BAUD);
    // Guarded so an illegal DIV reaches the elaboration error below instead
    // of a zero-width vector.
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_fifo: CLK_FREQ_HZ/BAUD must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    tx_state_t        state_r;
    tx_state_t        state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_next_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_next_s;
    logic             txd_r;
    logic             txd_next_s;
    logic             overflow_r;
    logic             pop_s;
    logic             period_end_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_rd_data_s;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop_s),
        .rd_data (fifo_rd_data_s),
        .level   (level),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign period_end_s = (cnt_r == CNT_LAST);
    assign full         = fifo_full_s;
    assign busy         = (state_r != IDLE) | ~fifo_empty_s;
    assign overflow     = overflow_r;
    assign txd          = txd_r;

    // Next-state, datapath and next line level for the transmitter FSM.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        pop_s          = 1'b0;
        txd_next_s     = LINE_IDLE;

        case (state_r)
            IDLE: begin
                cnt_next_s = {CNT_W{1'b0}};
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = fifo_rd_data_s;
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (period_end_s) begin
                    cnt_next_s     = {CNT_W{1'b0}};
                    bit_idx_next_s = 3'd0;
                    state_next_s   = DATA;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (period_end_s) begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    shift_next_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == BIT_LAST) begin
                        bit_idx_next_s = 3'd0;
                        state_next_s   = STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (period_end_s) begin
                    cnt_next_s = {CNT_W{1'b0}};
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = fifo_rd_data_s;
                        state_next_s = START;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                cnt_next_s     = {CNT_W{1'b0}};
                bit_idx_next_s = 3'd0;
                state_next_s   = IDLE;
            end
        endcase

        // Line level follows the state being entered so txd can be a plain
        // register with no combinational path from the write port.
        case (state_next_s)
            IDLE:    txd_next_s = LINE_IDLE;
            START:   txd_next_s = LINE_START;
            DATA:    txd_next_s = shift_next_s[0];
            STOP:    txd_next_s = LINE_IDLE;
            default: txd_next_s = LINE_IDLE;
        endcase
    end

    // Transmitter state, counters, shifter, line and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            txd_r      <= LINE_IDLE;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            bit_idx_r  <= bit_idx_next_s;
            shift_r    <= shift_next_s;
            txd_r      <= txd_next_s;
            // Uses the registered full, so a same-cycle pop does not rescue
            // the write.
            overflow_r <= overflow_r | (wr_en & fifo_full_s);
        end
    end

endmodule
